// File: rtl/pio_rx_pkg.sv
// Shared types and widths for the PIO nibble receiver.
// Holds the FSM state enum and strobe/nibble/byte widths.
package pio_rx_pkg;

  typedef enum logic {
    EXPECT_HI = 1'b0,
    EXPECT_LO = 1'b1
  } rx_state_e;

  localparam int STB_BIT = 4;
  localparam int NIB_W   = 4;
  localparam int BYTE_W  = 8;

endpackage

// File: rtl/pio_rx_fifo.sv
// DEPTH x BYTE_W circular FIFO; dout is the registered head entry.
// Ports: push/din, pop/dout, full, empty, level (bytes held).
module pio_rx_fifo
  import pio_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees the slot the push lands in, so full+pop still accepts.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pio_nibble_rx.sv
// Pairs strobed PIO nibbles into bytes (high first) and queues them.
// Ports: pio_in, ovf_clr, byte_* handshake, fifo_level, overflow,
// phase; timeout only when PIO_RX_TIMEOUT_EN is defined.
module pio_nibble_rx
  import pio_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [STB_BIT:0]  pio_in,
  input  logic              ovf_clr,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [LW-1:0]     fifo_level,
  output logic              overflow,
`ifdef PIO_RX_TIMEOUT_EN
  output logic              timeout,
`endif
  output logic              phase
);

  logic [STB_BIT:0]  s1;
  logic              s2_stb;
  rx_state_e         state;
  logic [NIB_W-1:0]  hi_nib;
  logic              tog;
  logic              push;
  logic              drop;
  logic              full;
  logic              empty;
  logic [BYTE_W-1:0] push_data;

  assign tog       = s1[STB_BIT] ^ s2_stb;
  assign push      = tog && (state == EXPECT_LO);
  assign push_data = {hi_nib, s1[NIB_W-1:0]};
  // Full implies non-empty, so byte_ready alone means a pop.
  assign drop      = push && full && !byte_ready;
  assign byte_valid = !empty;

`ifdef PIO_RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
`else
  logic unused_to;
  assign unused_to = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= '0;
      s2_stb   <= 1'b0;
      state    <= EXPECT_HI;
      phase    <= 1'b0;
      hi_nib   <= '0;
      overflow <= 1'b0;
`ifdef PIO_RX_TIMEOUT_EN
      to_cnt   <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      s1     <= pio_in;
      s2_stb <= s1[STB_BIT];

      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

`ifdef PIO_RX_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      unique case (state)
        EXPECT_HI: begin
`ifdef PIO_RX_TIMEOUT_EN
          to_cnt <= '0;
`endif
          if (tog) begin
            hi_nib <= s1[NIB_W-1:0];
            state  <= EXPECT_LO;
            phase  <= 1'b1;
          end
        end
        EXPECT_LO: begin
          if (tog) begin
            state  <= EXPECT_HI;
            phase  <= 1'b0;
`ifdef PIO_RX_TIMEOUT_EN
            to_cnt <= '0;
          end else if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the half byte so software can resync.
            state   <= EXPECT_HI;
            phase   <= 1'b0;
            hi_nib  <= '0;
            timeout <= 1'b1;
            to_cnt  <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
      endcase
    end
  end

  pio_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (push_data),
    .pop     (byte_ready),
    .dout    (byte_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

endmodule
